// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator driving the data port of the dual-port RAM.
// Latency: store 2, load 4, misaligned/DISABLE 1 cycle(s) from accept, plus 1 per mem_not_ready cycle.
// Backpressure: req_ready only in IDLE; mem_not_ready holds ISSUE; read timeout after TIMEOUT cycles.
module load_store_unit #(
    parameter logic [1:0] MEM_DISABLE   = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
    parameter logic [1:0] MEM_WRITE     = 2'b11,
    parameter int         TIMEOUT       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_web,
    output logic        mem_en,
    input  logic [31:0] mem_dout,
    input  logic        mem_read_valid,
    input  logic        mem_not_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESP} state_t;

    state_t        state;
    state_t        nextState;

    logic [1:0]    opQ;
    logic [1:0]    sizeQ;
    logic [31:0]   addrQ;
    logic [31:0]   wdataQ;
    logic [CW-1:0] waitCnt;

    logic [1:0]    curOp;
    logic [1:0]    curSize;
    logic [31:0]   curAddr;
    logic [31:0]   curWdata;
    logic          reqMisaligned;
    logic [31:0]   shifted;
    logic [31:0]   loadData;

    logic          memEnD;
    logic [3:0]    memWebD;
    logic [31:0]   memAddrD;
    logic [31:0]   memDinD;
    logic          respValidD;
    logic [31:0]   respRdataD;
    logic          respErrD;

    // In IDLE the request is still on the inputs; afterwards the latched copy is used.
    assign curOp    = (state == IDLE) ? req_op    : opQ;
    assign curSize  = (state == IDLE) ? req_size  : sizeQ;
    assign curAddr  = (state == IDLE) ? req_addr  : addrQ;
    assign curWdata = (state == IDLE) ? req_wdata : wdataQ;

    // Size 3 behaves as word, so size[1] covers both word encodings.
    assign reqMisaligned = ((req_size == 2'd1) && req_addr[0]) ||
                           (req_size[1] && (req_addr[1:0] != 2'b00));

    assign req_ready = (state == IDLE);

    // Right-align the addressed lane, then extend by size and signedness.
    assign shifted = mem_dout >> {addrQ[1:0], 3'b000};
    always_comb begin
        loadData = shifted;
        case (sizeQ)
            2'd0:    loadData = (opQ == MEM_READ_SEXT) ? {{24{shifted[7]}}, shifted[7:0]}
                                                       : {24'b0, shifted[7:0]};
            2'd1:    loadData = (opQ == MEM_READ_SEXT) ? {{16{shifted[15]}}, shifted[15:0]}
                                                       : {16'b0, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ((req_op == MEM_DISABLE) || reqMisaligned) nextState = RESP;
                    else                                          nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_not_ready) nextState = (opQ == MEM_WRITE) ? RESP : READ_WAIT;
            end
            READ_WAIT: begin
                if (mem_read_valid || (waitCnt == CW'(TIMEOUT - 1))) nextState = RESP;
            end
            default: nextState = IDLE;
        endcase
    end

    // Output logic: next values for the registered memory and response outputs.
    always_comb begin
        memEnD     = 1'b0;
        memWebD    = 4'b0000;
        memAddrD   = mem_addr;
        memDinD    = mem_din;
        respValidD = (nextState == RESP);
        respRdataD = resp_rdata;
        respErrD   = resp_err;
        if (nextState == ISSUE) begin
            memEnD   = 1'b1;
            memAddrD = curAddr;
            memDinD  = 32'b0;
            if (curOp == MEM_WRITE) begin
                case (curSize)
                    2'd0:    begin memWebD = 4'b0001 << curAddr[1:0]; memDinD = {4{curWdata[7:0]}};  end
                    2'd1:    begin memWebD = 4'b0011 << curAddr[1:0]; memDinD = {2{curWdata[15:0]}}; end
                    default: begin memWebD = 4'b1111;                 memDinD = curWdata;            end
                endcase
            end
        end
        if (nextState == RESP) begin
            respRdataD = 32'b0;
            respErrD   = 1'b0;
            case (state)
                IDLE:      respErrD = (req_op != MEM_DISABLE) && reqMisaligned;
                READ_WAIT: begin
                    if (mem_read_valid) respRdataD = loadData;
                    else                respErrD   = 1'b1;
                end
                default:   respErrD = 1'b0;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en     <= 1'b0;
            mem_web    <= 4'b0000;
            mem_addr   <= 32'b0;
            mem_din    <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
        end else begin
            mem_en     <= memEnD;
            mem_web    <= memWebD;
            mem_addr   <= memAddrD;
            mem_din    <= memDinD;
            resp_valid <= respValidD;
            resp_rdata <= respRdataD;
            resp_err   <= respErrD;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opQ    <= MEM_DISABLE;
            sizeQ  <= 2'd0;
            addrQ  <= 32'b0;
            wdataQ <= 32'b0;
        end else if (req_valid && (state == IDLE)) begin
            opQ    <= req_op;
            sizeQ  <= req_size;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
        end
    end

    // Read-wait cycle counter, zero on entry to READ_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  waitCnt <= '0;
        else if (state == READ_WAIT) waitCnt <= waitCnt + 1'b1;
        else                         waitCnt <= '0;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the data port (port B) of the dual-port RAM wrapper, placed in the memory stage of the RISC-V core.
- Takes one load/store request at a time from the pipeline and converts it into port-B byte-enable writes or reads.
- Waits for the RAM read-valid strobe and returns the sign- or zero-extended load data with a one-cycle response pulse.
- Flags misaligned accesses and read timeouts without touching memory state.

Parameters:
MEM_DISABLE, 2'b00, op encoding: no access
MEM_READ_SEXT, 2'b01, op encoding: load, sign-extend
MEM_READ_ZEXT, 2'b10, op encoding: load, zero-extend
MEM_WRITE, 2'b11, op encoding: store
TIMEOUT, 8, max cycles in READ_WAIT before an error response

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_op  in  2  MEM_* encoding
req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores, errors and DISABLE
resp_err  out  1  qualifies resp_valid: misaligned or timeout
mem_addr  out  32  to RAM addrB; RAM uses bits [16:2]
mem_din  out  32  to RAM dinB, lane-replicated
mem_web  out  4  to RAM web, byte enables
mem_en  out  1  to RAM enB
mem_dout  in  32  from RAM doutB
mem_read_valid  in  1  from RAM readValidB
mem_not_ready  in  1  from RAM NOTready

Behaviour:
- Reset: asynchronous and active-low. On assertion, state goes to IDLE and every registered output clears: resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_din=0, mem_web=0, mem_en=0. req_ready=1 immediately on assertion. Reset mid-operation abandons the transaction; a later mem_read_valid is ignored.
- States: IDLE, ISSUE, READ_WAIT, RESP.
- IDLE (req_ready=1):
  - On req_valid, latch op, size, addr and wdata; req_ready drops the next cycle.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) and any op other than DISABLE: go to RESP with err=1. Memory is never driven.
  - DISABLE: go to RESP with err=0, rdata=0.
  - Otherwise go to ISSUE.
- ISSUE: drive registered mem_en=1 and mem_addr=latched addr.
  - Write: mem_web = base<<addr[1:0], with base 0001/0011/1111 for byte/half/word. mem_din = {4{wdata[7:0]}} / {2{wdata[15:0]}} / wdata.
  - Read: mem_web=0000, mem_din=0.
  - If mem_not_ready=1 in this cycle, stay in ISSUE and re-drive the same values. Otherwise a write goes to RESP and a read goes to READ_WAIT.
  - mem_en and mem_web are 0 in every state except ISSUE.
- READ_WAIT: RAM read-valid arrives 2 cycles after the enable cycle.
  - On mem_read_valid=1, capture mem_dout >> (8*addr[1:0]), extract 8/16/32 bits by size, sign-extend for SEXT or zero-extend for ZEXT, then go to RESP.
  - A cycle counter starts at 0 on entry. If it reaches TIMEOUT without read-valid, go to RESP with err=1, rdata=0.
  - mem_read_valid in any other state is ignored.
- RESP: resp_valid=1 for exactly one cycle with the registered rdata/err, then IDLE.
- Latency, request accept edge to resp_valid, with no stalls: store 2 cycles, load 4 cycles, misaligned/DISABLE 1 cycle. Each mem_not_ready cycle adds 1.
- A new request is accepted no earlier than the cycle after resp_valid, so throughput is at most one transaction per 3 cycles (write) or 5 cycles (read).
- resp_rdata holds its value until the next response; resp_err clears on the next resp_valid.

Test Plan:
1. Reset low mid-READ_WAIT, release, then pulse mem_read_valid -> all outputs 0, req_ready=1, no resp_valid.
2. Store byte, addr=0x103, wdata=0xAB -> one ISSUE cycle with mem_web=1000, mem_din=0xABABABAB, mem_addr=0x103; resp_valid 2 cycles after accept, rdata=0, err=0.
3. Load half SEXT, addr=0x102, mem_dout=0x8001_1234, read_valid 2 cycles after ISSUE -> resp_rdata=0xFFFF8001. Same stimulus with ZEXT -> 0x00008001. Byte ZEXT at addr=0x101 -> 0x00000012.
4. Word load at addr=0x202 -> no mem_en, resp_valid 1 cycle after accept with err=1, rdata=0. Half store at addr=0x201 -> same error response.
5. mem_not_ready=1 for 3 cycles during a word store -> ISSUE held 4 cycles with identical mem_* values; resp_valid 5 cycles after accept.
6. Word load with read-valid never returned -> resp_valid with err=1 after TIMEOUT=8 cycles in READ_WAIT; the next request is accepted normally.
